// File: rtl/frame_feeder.sv
// Skid FIFO feeding framed 32-bit words to a comparator, with clear/flush sequencing around each frame.
// Latency: 2 cycles from accept to data_out when streaming; in_ready drops when the FIFO is full.
// FRAME_FEEDER_STATS_EN builds the frame/error counters; without it both counters read zero.
module frame_feeder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_empty,
    output logic        in_ready,
    output logic [31:0] data_out,
    output logic        word_valid,
    output logic        clear,
    output logic        frame_active,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   PTR_FULL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FRAME, FLUSH} state_t;

    state_t        state_q;
    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_vis_q, rd_ptr_q, used;
    logic [FW-1:0] flush_cnt_q;
    logic [31:0]   data_out_q;
    logic          word_valid_q, clear_q, frame_active_q, in_rst_q;
    logic          push, head_vld, head_sop, head_eop;
    logic [1:0]    head_emp;
    logic [31:0]   head_dat;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign in_ready = !rst && (used != PTR_FULL);
    assign push     = in_valid && in_ready;
    assign {head_dat, head_sop, head_eop, head_emp} = mem_q[rd_ptr_q[AW-1:0]];
    // An entry becomes visible to the sequencer one cycle after it is written.
    assign head_vld = (wr_vis_q != rd_ptr_q);

    function automatic logic [31:0] mask_tail(input logic [31:0] d, input logic [1:0] e);
        case (e)
            2'd1:    return {d[31:8], 8'h00};
            2'd2:    return {d[31:16], 16'h0000};
            2'd3:    return {d[31:24], 24'h000000};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_data, in_sop, in_eop, in_empty};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            wr_vis_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            wr_vis_q <= wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            flush_cnt_q    <= '0;
            data_out_q     <= '0;
            word_valid_q   <= 1'b0;
            clear_q        <= 1'b0;
            frame_active_q <= 1'b0;
            in_rst_q       <= 1'b1;
        end else begin
            in_rst_q     <= 1'b0;
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            clear_q      <= in_rst_q;
            case (state_q)
                IDLE: begin
                    frame_active_q <= 1'b0;
                    if (head_vld) begin
                        if (head_sop) begin
                            state_q <= CLEAR;
                            clear_q <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        end
                    end
                end
                CLEAR: state_q <= FRAME;
                FRAME: begin
                    if (head_vld) begin
                        // A second sop before eop aborts the open frame and restarts on the new one.
                        if (head_sop && frame_active_q) begin
                            state_q        <= CLEAR;
                            clear_q        <= 1'b1;
                            frame_active_q <= 1'b0;
                        end else begin
                            rd_ptr_q       <= rd_ptr_q + PTR_ONE;
                            data_out_q     <= head_eop ? mask_tail(head_dat, head_emp) : head_dat;
                            word_valid_q   <= 1'b1;
                            frame_active_q <= 1'b1;
                            if (head_eop) begin
                                state_q     <= FLUSH;
                                flush_cnt_q <= '0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) state_q <= IDLE;
                    else flush_cnt_q <= flush_cnt_q + FW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign word_valid   = word_valid_q;
    assign clear        = clear_q;
    assign frame_active = frame_active_q;

`ifdef FRAME_FEEDER_STATS_EN
    logic        frame_done, err_evt;
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    assign frame_done = (state_q == FLUSH) && (flush_cnt_q == FLUSH_LAST);
    assign err_evt    = head_vld && (((state_q == IDLE) && !head_sop) ||
                                     ((state_q == FRAME) && head_sop && frame_active_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_done && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_evt && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign err_count   = err_cnt_q;
`else
    assign frame_count = '0;
    assign err_count   = '0;
`endif
endmodule

// File: tb/tb_frame_feeder.sv
// Bench for frame_feeder: directed scenarios plus a randomized stream checked against a frame-parser model.
module tb_frame_feeder;
    localparam int FLUSH_CYCLES = 3;
`ifdef FRAME_FEEDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop;
    logic [1:0]  in_empty;
    logic        in_ready;
    logic [31:0] data_out;
    logic        word_valid, clear, frame_active;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    frame_feeder #(.FIFO_DEPTH(4), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_empty(in_empty), .in_ready(in_ready), .data_out(data_out),
        .word_valid(word_valid), .clear(clear), .frame_active(frame_active),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_errs = 0;
    logic [31:0] got_q[$];
    int clear_cnt = 0;

    always @(negedge clk) begin
        if (word_valid) got_q.push_back(data_out);
        if (clear) clear_cnt++;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] d, input logic eop, input logic [1:0] emp);
        logic [31:0] keep;
        keep = 32'hFFFF_FFFF << (8 * int'(emp));
        return eop ? (d & keep) : d;
    endfunction

    function logic [15:0] exp_frm();
        return STATS ? ((exp_frames > 65535) ? 16'hFFFF : 16'(exp_frames)) : 16'h0000;
    endfunction

    function logic [7:0] exp_err();
        return STATS ? ((exp_errs > 255) ? 8'hFF : 8'(exp_errs)) : 8'h00;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic push(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m, output bit ok);
        int w;
        w = 0;
        in_data = d; in_sop = s; in_eop = e; in_empty = m; in_valid = 1'b1;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, output bit ok);
        int w;
        w = 0;
        while (got_q.size() < n && w < 2000) begin
            @(negedge clk);
            w++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
        if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got=%b exp=0", clear); end
        if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b exp=0", frame_active); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (clear !== 1'b1) begin errors++; $display("FAIL reset_exit_clear got=%b exp=1", clear); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_exit_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++;
        if (clear !== 1'b0) begin errors++; $display("FAIL reset_exit_clear_drop got=%b exp=0", clear); end
        exp_frames = 0; exp_errs = 0;
        idle(2);
    endtask

    task automatic test_basic_frame();
        logic [31:0] ed;
        logic ev, ec, ea;
        in_data = 32'hDEADBEEF; in_sop = 1'b1; in_eop = 1'b0; in_empty = 2'd0; in_valid = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ec = (k == 2);
            ev = (k == 4) || (k == 5);
            ed = (k == 4) ? 32'hDEADBEEF : (k == 5) ? 32'h0011AABB : 32'h0;
            ea = (k >= 4) && (k <= 5 + FLUSH_CYCLES);
            checks += 4;
            if (clear !== ec) begin errors++; $display("FAIL basic_clear k=%0d got=%b exp=%b", k, clear, ec); end
            if (word_valid !== ev) begin errors++; $display("FAIL basic_word_valid k=%0d got=%b exp=%b", k, word_valid, ev); end
            if (data_out !== ed) begin errors++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, data_out, ed); end
            if (frame_active !== ea) begin errors++; $display("FAIL basic_frame_active k=%0d got=%b exp=%b", k, frame_active, ea); end
            if (k == 0) begin in_data = 32'h0011AABB; in_sop = 1'b0; in_eop = 1'b1; end
            else in_valid = 1'b0;
        end
        exp_frames++;
        checks++;
        if (frame_count !== exp_frm()) begin errors++; $display("FAIL basic_frame_count got=%0d exp=%0d", frame_count, exp_frm()); end
    endtask

    task automatic test_latency();
        logic [31:0] x, y;
        logic [1:0] m;
        int base;
        bit ok;
        base = got_q.size();
        x = $urandom; y = $urandom; m = 2'($urandom_range(0, 3));
        push(x, 1'b1, 1'b0, 2'd0, ok);
        idle(6);
        checks += 3;
        if (word_valid !== 1'b0 || frame_active !== 1'b1) begin
            errors++; $display("FAIL latency_starved got_wv=%b got_fa=%b exp_wv=0 exp_fa=1", word_valid, frame_active);
        end
        if (got_q[base] !== x) begin errors++; $display("FAIL latency_first_word got=%h exp=%h", got_q[base], x); end
        if (!ok) begin errors++; $display("FAIL latency_push got=blocked exp=accepted"); end
        in_data = y; in_sop = 1'b0; in_eop = 1'b1; in_empty = m; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL latency_t0 got=%b exp=0", word_valid); end
        @(negedge clk);
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL latency_t1 got=%b exp=0", word_valid); end
        @(negedge clk);
        checks += 2;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL latency_t2_valid got=%b exp=1", word_valid); end
        if (data_out !== exp_word(y, 1'b1, m)) begin errors++; $display("FAIL latency_t2_data got=%h exp=%h", data_out, exp_word(y, 1'b1, m)); end
        idle(FLUSH_CYCLES + 4);
        exp_frames++;
        checks++;
        if (frame_count !== exp_frm()) begin errors++; $display("FAIL latency_frame_count got=%0d exp=%0d", frame_count, exp_frm()); end
    endtask

    task automatic test_mask();
        logic [31:0] d[6];
        logic s[6], e[6];
        logic [1:0] m[6];
        int base, cbase;
        bit ok, all_ok;
        base = got_q.size(); cbase = clear_cnt; all_ok = 1'b1;
        d[0] = 32'hA5A5A5A5; s[0] = 1'b1; e[0] = 1'b0; m[0] = 2'd3;
        d[1] = 32'h12345678; s[1] = 1'b0; e[1] = 1'b1; m[1] = 2'd2;
        for (int i = 2; i < 6; i++) begin
            d[i] = $urandom; s[i] = 1'b1; e[i] = 1'b1; m[i] = 2'(i - 2);
        end
        for (int i = 0; i < 6; i++) begin
            push(d[i], s[i], e[i], m[i], ok);
            all_ok &= ok;
        end
        wait_words(base + 6, ok);
        idle(FLUSH_CYCLES + 4);
        exp_frames += 5;
        checks += 5;
        if (!(ok && all_ok)) begin errors++; $display("FAIL mask_timeout got=%0d words exp=6", got_q.size() - base); end
        if (got_q[base + 1] !== 32'h12340000) begin errors++; $display("FAIL mask_empty2 got=%h exp=12340000", got_q[base + 1]); end
        if (got_q.size() !== base + 6) begin errors++; $display("FAIL mask_count got=%0d exp=6", got_q.size() - base); end
        if (clear_cnt - cbase !== 5) begin errors++; $display("FAIL mask_clears got=%0d exp=5", clear_cnt - cbase); end
        if (frame_count !== exp_frm()) begin errors++; $display("FAIL mask_frame_count got=%0d exp=%0d", frame_count, exp_frm()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_q[base + i] !== exp_word(d[i], e[i], m[i])) begin
                errors++; $display("FAIL mask_word%0d got=%h exp=%h", i, got_q[base + i], exp_word(d[i], e[i], m[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d[5];
        int base;
        bit ok, all_ok;
        base = got_q.size(); all_ok = 1'b1;
        for (int i = 0; i < 5; i++) d[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            push(d[i], i == 0, i == 4, 2'd0, ok);
            all_ok &= ok;
            if (i == 2) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after3 got=%b exp=1", in_ready); end
            end
            if (i == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_after4 got=%b exp=0", in_ready); end
            end
        end
        wait_words(base + 5, ok);
        idle(FLUSH_CYCLES + 4);
        exp_frames++;
        checks++;
        if (!(ok && all_ok)) begin errors++; $display("FAIL b2b_timeout got=%0d words exp=5", got_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q[base + i] !== d[i]) begin errors++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[base + i], d[i]); end
        end
    endtask

    task automatic test_discard();
        int base, cbase;
        bit ok;
        base = got_q.size(); cbase = clear_cnt;
        push(32'h55555555, 1'b0, 1'b0, 2'd0, ok);
        idle(8);
        exp_errs++;
        checks += 4;
        if (!ok) begin errors++; $display("FAIL discard_push got=blocked exp=accepted"); end
        if (got_q.size() !== base) begin errors++; $display("FAIL discard_output got=%0d words exp=0", got_q.size() - base); end
        if (clear_cnt !== cbase) begin errors++; $display("FAIL discard_clear got=%0d pulses exp=0", clear_cnt - cbase); end
        if (err_count !== exp_err()) begin errors++; $display("FAIL discard_err_count got=%0d exp=%0d", err_count, exp_err()); end
    endtask

    task automatic test_abort();
        logic [31:0] d[4];
        logic [1:0] m;
        int base, cbase;
        bit ok, all_ok;
        base = got_q.size(); cbase = clear_cnt; all_ok = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        m = 2'd1;
        for (int i = 0; i < 4; i++) begin
            push(d[i], (i == 0) || (i == 2), i == 3, m, ok);
            all_ok &= ok;
        end
        wait_words(base + 4, ok);
        idle(FLUSH_CYCLES + 4);
        exp_errs++; exp_frames++;
        checks += 4;
        if (!(ok && all_ok)) begin errors++; $display("FAIL abort_timeout got=%0d words exp=4", got_q.size() - base); end
        if (clear_cnt - cbase !== 2) begin errors++; $display("FAIL abort_clears got=%0d exp=2", clear_cnt - cbase); end
        if (err_count !== exp_err()) begin errors++; $display("FAIL abort_err_count got=%0d exp=%0d", err_count, exp_err()); end
        if (frame_count !== exp_frm()) begin errors++; $display("FAIL abort_frame_count got=%0d exp=%0d", frame_count, exp_frm()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[base + i] !== exp_word(d[i], i == 3, m)) begin
                errors++; $display("FAIL abort_word%0d got=%h exp=%h", i, got_q[base + i], exp_word(d[i], i == 3, m));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d[$];
        logic s[$], e[$];
        logic [1:0] m[$];
        logic [31:0] exp_q[$];
        int base, cbase, exp_clears;
        bit still_open, in_frame, ok, all_ok;
        base = got_q.size(); cbase = clear_cnt; still_open = 1'b0; all_ok = 1'b1;
        for (int i = 0; i < 150; i++) begin
            d.push_back($urandom);
            s.push_back($urandom_range(0, 3) == 0);
            e.push_back($urandom_range(0, 9) < 3);
            m.push_back(2'($urandom_range(0, 3)));
            still_open = s[i] ? !e[i] : (still_open && !e[i]);
        end
        if (still_open) begin d.push_back($urandom); s.push_back(1'b0); e.push_back(1'b1); m.push_back(2'd0); end
        foreach (d[i]) begin
            push(d[i], s[i], e[i], m[i], ok);
            all_ok &= ok;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        // Frame parser: sop opens (aborting any open frame), eop closes, strays outside a frame are errors.
        in_frame = 1'b0; exp_clears = 0;
        foreach (d[i]) begin
            if (s[i]) begin
                if (in_frame) exp_errs++;
                exp_clears++;
                in_frame = 1'b1;
            end else if (!in_frame) begin
                exp_errs++;
                continue;
            end
            exp_q.push_back(exp_word(d[i], e[i], m[i]));
            if (e[i]) begin exp_frames++; in_frame = 1'b0; end
        end
        wait_words(base + exp_q.size(), ok);
        idle(FLUSH_CYCLES + 6);
        checks += 5;
        if (!(ok && all_ok)) begin errors++; $display("FAIL random_timeout got=%0d words exp=%0d", got_q.size() - base, exp_q.size()); end
        if (got_q.size() !== base + exp_q.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", got_q.size() - base, exp_q.size()); end
        if (clear_cnt - cbase !== exp_clears) begin errors++; $display("FAIL random_clears got=%0d exp=%0d", clear_cnt - cbase, exp_clears); end
        if (frame_count !== exp_frm()) begin errors++; $display("FAIL random_frame_count got=%0d exp=%0d", frame_count, exp_frm()); end
        if (err_count !== exp_err()) begin errors++; $display("FAIL random_err_count got=%0d exp=%0d", err_count, exp_err()); end
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_midframe_reset();
        int base;
        bit ok;
        push(32'h11112222, 1'b1, 1'b0, 2'd0, ok);
        push(32'h33334444, 1'b0, 1'b0, 2'd0, ok);
        rst = 1'b1;
        idle(2);
        checks += 6;
        if (data_out !== 32'd0 || word_valid !== 1'b0) begin errors++; $display("FAIL mrst_outputs got=%h/%b exp=0/0", data_out, word_valid); end
        if (frame_active !== 1'b0) begin errors++; $display("FAIL mrst_frame_active got=%b exp=0", frame_active); end
        if (clear !== 1'b0) begin errors++; $display("FAIL mrst_clear got=%b exp=0", clear); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL mrst_frame_count got=%0d exp=0", frame_count); end
        if (err_count !== 8'd0) begin errors++; $display("FAIL mrst_err_count got=%0d exp=0", err_count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        exp_frames = 0; exp_errs = 0;
        base = got_q.size();
        @(negedge clk);
        checks++;
        if (clear !== 1'b1) begin errors++; $display("FAIL mrst_exit_clear got=%b exp=1", clear); end
        idle(10);
        checks += 2;
        if (got_q.size() !== base) begin errors++; $display("FAIL mrst_leftover got=%0d words exp=0", got_q.size() - base); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL mrst_partial_counted got=%0d exp=0", frame_count); end
    endtask

    task automatic test_saturation();
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < 258; i++) begin
            push($urandom, 1'b0, 1'($urandom_range(0, 1)), 2'd0, ok);
            all_ok &= ok;
        end
        idle(10);
        exp_errs += 258;
        checks += 2;
        if (!all_ok) begin errors++; $display("FAIL sat_push got=blocked exp=accepted"); end
        if (err_count !== exp_err()) begin errors++; $display("FAIL sat_err_count got=%0d exp=%0d", err_count, exp_err()); end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_latency();
        test_mask();
        test_back_to_back();
        test_discard();
        test_abort();
        test_random();
        test_midframe_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
